// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state encoding and width for the multiply/divide unit FSMs.
package mdu_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;
endpackage

// File: rtl/mdu_iter_divider_div_step.sv
// div_step: one radix-2 restoring division step on {rem,quo}.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/mdu_iter_divider.sv
// mdu_iter_divider: iterative restoring DIV/DIVU for the EXE stage, one quotient bit per cycle.
module mdu_iter_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  input  logic             div_flush,
  input  logic             div_ack,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder
);
  div_state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvsr, rem_nx, quo_nx, a_mag, b_mag;
  logic q_neg, r_neg, a_neg, b_neg, accept, calc, last;
  assign a_neg  = div_signed & div_dividend[WIDTH-1];
  assign b_neg  = div_signed & div_divisor[WIDTH-1];
  assign a_mag  = a_neg ? -div_dividend : div_dividend;
  assign b_mag  = b_neg ? -div_divisor : div_divisor;
  assign accept = state == DIV_IDLE && div_start && !div_flush;
  assign calc   = state == DIV_CALC && !div_flush;
  assign last   = cnt == CNT_W'(WIDTH - 1);
  // combinational so the pipeline freezes in the very cycle the start appears
  assign div_busy = resetn && !div_flush && ((state == DIV_IDLE && div_start) || state == DIV_CALC);
  assign div_done = state == DIV_DONE;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );
  always_comb begin
    next = div_flush                           ? DIV_IDLE :
           accept                              ? DIV_CALC :
           (state == DIV_CALC && last)         ? DIV_DONE :
           (state == DIV_DONE && div_ack)      ? DIV_IDLE : state;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= DIV_IDLE;
    else         state <= next;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      dvsr          <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (accept) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= a_mag;
      dvsr  <= b_mag;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
    end else if (calc) begin
      cnt <= cnt + CNT_W'(1);
      rem <= rem_nx;
      quo <= quo_nx;
      if (last) begin
        div_quotient  <= q_neg ? -quo_nx : quo_nx;
        div_remainder <= r_neg ? -rem_nx : rem_nx;
      end
    end
  end
endmodule

// File: tb/tb_mdu_iter_divider.sv
// tb_mdu_iter_divider: directed DIV/DIVU vectors checked against an arithmetic model every cycle.
module tb_mdu_iter_divider;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_start = 1'b0, div_signed = 1'b0, div_flush = 1'b0, div_ack = 1'b0;
  logic [31:0] div_dividend = '0, div_divisor = '0;
  logic        div_busy, div_done;
  logic [31:0] div_quotient, div_remainder;
  int checks = 0;
  int errors = 0;

  mdu_iter_divider dut (
    .clk           (clk),
    .resetn        (resetn),
    .div_start     (div_start),
    .div_signed    (div_signed),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_flush     (div_flush),
    .div_ack       (div_ack),
    .div_busy      (div_busy),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // truncating division; divide-by-zero yields all-ones magnitude and the dividend as remainder
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 0) return {(s && a[31]) ? 32'd1 : 32'hFFFF_FFFF, a};
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else if (div_flush) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (div_ack) m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_q    <= p_q;
        m_r    <= p_r;
      end
    end else if (div_start) begin
      m_left <= 32;
      {p_q, p_r} <= model_div(div_dividend, div_divisor, div_signed);
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, div_busy},
          {31'd0, resetn && !div_flush && ((m_left == 0 && !m_done && div_start) || m_left > 0)});
    check("done", {31'd0, div_done}, {31'd0, m_done});
    check("quotient", div_quotient, m_q);
    check("remainder", div_remainder, m_r);
  end

  task automatic wait_done(output int busy_n, output int lat);
    busy_n = 0;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (div_done) begin
        lat = i;
        break;
      end
      if (div_busy) busy_n++;
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    div_dividend = a;
    div_divisor  = b;
    div_signed   = s;
    div_start    = 1'b1;
  endtask

  task automatic retire();
    @(posedge clk); #1;
    div_ack = 1'b1;
    @(posedge clk); #1;
    div_ack   = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    check("busy_after_ack", {31'd0, div_busy}, 32'd0);
  endtask

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er);
    int busy_n, lat;
    issue(a, b, s);
    wait_done(busy_n, lat);
    check({name, "_busy_cycles"}, busy_n, 33);
    check({name, "_latency"}, lat, 33);
    check({name, "_q"}, div_quotient, eq);
    check({name, "_r"}, div_remainder, er);
    retire();
  endtask

  initial begin
    int busy_n, lat;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_n, lat;
    div_start = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, div_busy}, 32'd0);
    check("reset_done", {31'd0, div_done}, 32'd0);
    check("reset_q", div_quotient, 32'd0);
    check("reset_r", div_remainder, 32'd0);
    @(posedge clk); #1;
    div_start = 1'b0;
    resetn = 1'b1;

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_div("divu_by0", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234);
    run_div("div_m5_by0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'd1, 32'hFFFF_FFFB);
    run_div("divu_big", 32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15);

    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 div_flush = 1'b1;
    @(negedge clk);
    check("flush_busy", {31'd0, div_busy}, 32'd0);
    @(posedge clk); #1;
    div_flush = 1'b0;
    div_start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("flush_no_done", {31'd0, div_done | div_busy}, 32'd0);
    end
    @(posedge clk); #1;
    div_start = 1'b1;
    div_flush = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_blocks_start", {31'd0, div_busy}, 32'd0);
    end
    @(posedge clk); #1;
    div_start = 1'b0;
    div_flush = 1'b0;
    @(negedge clk);
    check("flush_start_not_taken", {31'd0, div_busy}, 32'd0);

    issue(32'd50, 32'd6, 1'b0);
    wait_done(busy_n, lat);
    check("held_latency", lat, 33);
    repeat (5) begin
      @(negedge clk);
      check("held_done", {31'd0, div_done}, 32'd1);
      check("held_busy", {31'd0, div_busy}, 32'd0);
      check("held_q", div_quotient, 32'd8);
      check("held_r", div_remainder, 32'd2);
    end
    @(posedge clk); #1;
    div_ack = 1'b1;
    @(posedge clk); #1;
    div_ack = 1'b0;
    div_dividend = 32'd9;
    div_divisor  = 32'd3;
    wait_done(busy_n, lat);
    check("b2b_busy_cycles", busy_n, 33);
    check("b2b_latency", lat, 33);
    check("b2b_q", div_quotient, 32'd3);
    check("b2b_r", div_remainder, 32'd0);
    retire();

    issue(32'd1000, 32'd10, 1'b0);
    repeat (20) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("areset_busy", {31'd0, div_busy}, 32'd0);
    check("areset_done", {31'd0, div_done}, 32'd0);
    check("areset_q", div_quotient, 32'd0);
    check("areset_r", div_remainder, 32'd0);
    div_start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {31'd0, div_busy | div_done}, 32'd0);
    run_div("after_reset", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_iter_divider.md
Name: mdu_iter_divider

Overview:
- Iterative radix-2 restoring divider for MIPS DIV/DIVU, located in the EXE stage.
- Its busy output drives the pipeline controller's DIVMULTBusy input, which freezes every stage while a division runs.
- The result is written to HI/LO only when the EXE stage advances.
- An exception flush cancels an in-flight division immediately, so the controller's flush path is never blocked.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- div_start  in  1  EXE holds a valid DIV/DIVU instruction; held high while it sits in EXE.
- div_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- div_dividend  in  WIDTH  rs operand, sampled only on an accepted start.
- div_divisor  in  WIDTH  rt operand, sampled only on an accepted start.
- div_flush  in  1  exception flush (Flush_Exception).
- div_ack  in  1  EXE stage advances this cycle (EXE_Wr & ~EXE_DisWr).
- div_busy  out  1  stall request to the controller.
- div_done  out  1  result valid and held.
- div_quotient  out  WIDTH  LO value.
- div_remainder  out  WIDTH  HI value.

Behaviour:
Reset and clock
- Async on resetn low: state=IDLE, counter=0, all datapath registers 0.
- Outputs during reset: div_busy=0, div_done=0, div_quotient=0, div_remainder=0.
- All other updates occur on posedge clk.

State machine (IDLE, CALC, DONE)
- IDLE:
  - Start is accepted when div_start=1 and div_flush=0.
  - On the accepting edge: latch |dividend| and |divisor| (raw values when div_signed=0), latch quotient sign = sign(a)^sign(b) and remainder sign = sign(a) (both 0 if unsigned). Clear the partial remainder and counter, then go to CALC.
- CALC:
  - One restoring step per cycle: shift {rem,quo} left 1; trial = rem - divisor (WIDTH+1 bits); if trial is non-negative, rem=trial and quotient LSB=1.
  - Counter increments every cycle. On the edge where counter==WIDTH-1: apply sign fixup (two's-complement negate where the latched sign is 1), register the results, go to DONE.
- DONE:
  - div_done=1; results stay stable.
  - div_ack=1 returns to IDLE on the next edge.
  - div_start is ignored in DONE, so the same instruction is never restarted.

div_busy (combinational, so the controller stalls in the same cycle as the start)
- div_busy = ~div_flush & ((IDLE & div_start) | CALC).
- div_busy is 0 in DONE. The controller therefore releases the stall and div_ack follows.

Latency
- Start seen in cycle 0; div_busy high for cycles 0..WIDTH (33 cycles at WIDTH=32); div_done first high in cycle WIDTH+1.

Flush
- div_flush=1 in any state forces div_busy=0 in the same cycle and state=IDLE on the next edge. Partial results are discarded and div_done drops.
- Flush has priority over start and ack in the same cycle.

Arithmetic corner cases
- Divisor 0: quotient = all ones (0xFFFFFFFF before sign fixup), remainder = |dividend|, then normal sign fixup. This is deterministic, not trapped.
- 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0. Magnitudes are handled as unsigned WIDTH bits, so no overflow flag is raised.

Sequencing
- Back-to-back divides: ack returns to IDLE, and the next instruction's start is accepted on the following cycle.
- Reset mid-CALC: returns immediately to the reset values.

Decomposition:
Shared package (mdu_pkg)
- div_state_t enum {DIV_IDLE, DIV_CALC, DIV_DONE}.
- DIV_WIDTH constant.
- Shared with the future multiplier FSM.

Sub-module
- One combinational step module, div_step: inputs rem, quo, divisor; outputs next rem, next quo. Keeps the FSM readable and allows later radix-4 substitution.
- The sign fixup stays inline.

Test Plan:
- Basic unsigned: DIVU 100/7 → busy 33 cycles; done in cycle 33; quotient 14, remainder 2; ack → IDLE, busy stays 0.
- Signed rounding: DIV -7/2 (0xFFFFFFF9, 2) → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); and DIV 7/-2 → quotient -3, remainder 1.
- Corner cases: DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0x1234/0 → quotient 0xFFFFFFFF, remainder 0x1234.
- Flush mid-CALC: flush at cycle 10 → busy 0 in cycle 10, IDLE at cycle 11, done never asserted. Start held with flush=1 is not accepted.
- Held start and back-to-back: start held through DONE with ack=0 for 5 cycles → results stable, no restart. Ack with a new start (9/3) next cycle → quotient 3, remainder 0 after 33 more cycles.
- Async reset mid-CALC: resetn low at cycle 20 → all outputs 0 immediately without a clock edge; after release, IDLE and a fresh start works.
